// File: rtl/counter_pkg.sv
// Shared types and constants for the 4-bit counter stages and their consumers.
package counter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } trk_state_t;

endpackage

// File: rtl/snap_fifo2.sv
// Two-entry snapshot FIFO; head is always r_ent0 so the output is a plain register.
// Push while full without a pop is dropped and flagged with a one-cycle o_ovf pulse.
module snap_fifo2 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_ovf
);

  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_full;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_full = (r_cnt == 2'd2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= 2'd0;
    end else if (i_clr) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_ent0 <= i_dat;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          // push+pop with one entry: the new value replaces the head in place
          if (i_push && w_pop) begin
            r_ent0 <= i_dat;
          end else if (i_push) begin
            r_ent1 <= i_dat;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt  <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_ent0 <= r_ent1;
            if (i_push) begin
              r_ent1 <= i_dat;
            end else begin
              r_cnt  <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_dat   = r_ent0;
  assign o_empty = (r_cnt == 2'd0);
  assign o_ovf   = i_push && w_full && !w_pop && !i_clr;

endmodule

// File: rtl/counter_wrap_tracker.sv
// Checks a free-running 4-bit counter steps by +1, extends it with a wrap count and
// queues a wrap snapshot per rollover (1-cycle latency); snap_valid is independent of snap_ready.
module counter_wrap_tracker
  import counter_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      q,
  input  logic                  clr,
  input  logic                  snap_ready,
  output logic                  snap_valid,
  output logic [WRAP_W-1:0]     snap_data,
  output logic [WRAP_W+CNT_W-1:0] ext_count,
  output logic                  step_err,
  output logic                  ovf,
  output logic [1:0]            state
);

  localparam logic [CNT_W-1:0]  Q_ONE    = CNT_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  trk_state_t        r_state;
  logic [CNT_W-1:0]  r_q_prev;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_step_err;
  logic              r_ovf;

  logic              w_legal;
  logic              w_wrap;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_drop;
  logic [WRAP_W-1:0] w_wrap_nxt;
  logic [WRAP_W-1:0] w_head;

  assign w_legal    = (q == r_q_prev + Q_ONE);
  assign w_wrap     = (r_q_prev == '1) && (q == '0);
  assign w_wrap_nxt = r_wrap_cnt + WRAP_ONE;
  assign w_push     = (r_state == TRACK) && w_wrap && !clr;
  assign w_pop      = !w_empty && snap_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SYNC;
      r_q_prev   <= '0;
      r_wrap_cnt <= '0;
      r_step_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_q_prev <= q;
      if (clr) begin
        r_state    <= SYNC;
        r_wrap_cnt <= '0;
        r_step_err <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        case (r_state)
          SYNC: r_state <= TRACK;
          TRACK: begin
            if (!w_legal) begin
              r_step_err <= 1'b1;
              r_state    <= FAULT;
            end else if (w_wrap) begin
              r_wrap_cnt <= w_wrap_nxt;
            end
          end
          FAULT: ;
          default: r_state <= SYNC;
        endcase
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  snap_fifo2 #(
    .W (WRAP_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_dat   (w_wrap_nxt),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_empty (w_empty),
    .o_ovf   (w_drop)
  );

  assign snap_valid = !w_empty;
  assign snap_data  = w_head;
  assign ext_count  = {r_wrap_cnt, r_q_prev};
  assign step_err   = r_step_err;
  assign ovf        = r_ovf;
  assign state      = r_state;

endmodule

// File: tb/tb_counter_wrap_tracker.sv
// Bench for counter_wrap_tracker: two instances (WRAP_W=8 and WRAP_W=2) share one stimulus
// stream and are compared to a queue-based reference model plus hand-derived expectations.
module tb_counter_wrap_tracker;
  import counter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        snap_ready;
  logic [3:0]  q;

  logic        v8, v2, er8, er2, o8, o2;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [11:0] e8;
  logic [5:0]  e2;
  logic [1:0]  s8, s2;

  always #5 clk = ~clk;

  counter_wrap_tracker #(.WRAP_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .q(q), .clr(clr), .snap_ready(snap_ready),
    .snap_valid(v8), .snap_data(d8), .ext_count(e8),
    .step_err(er8), .ovf(o8), .state(s8)
  );

  counter_wrap_tracker #(.WRAP_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .q(q), .clr(clr), .snap_ready(snap_ready),
    .snap_valid(v2), .snap_data(d2), .ext_count(e2),
    .step_err(er2), .ovf(o2), .state(s2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int c;
  int m_state, m_prev, m_wraps, m_err, m_ovf;
  int m_fifo[$];
  bit cap;
  int cap8[$];
  int cap2[$];

  typedef struct {
    logic [3:0] q;
    logic       clr;
    logic       rdy;
    int         st;
    int         err;
    int         vld;
    int         dat;
    int         ext;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_prev = 0; m_wraps = 0; m_err = 0; m_ovf = 0;
    m_fifo.delete();
  endtask

  // Behavioural model of one clock edge, evaluated on the pre-edge inputs.
  task automatic m_edge();
    int occ;
    bit pop, push;
    occ  = m_fifo.size();
    pop  = (occ > 0) && snap_ready;
    push = 1'b0;
    if (clr) begin
      m_state = 0; m_wraps = 0; m_err = 0; m_ovf = 0;
      m_fifo.delete();
    end else begin
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (int'(q) != (m_prev + 1) % 16) begin
          m_err = 1; m_state = 2;
        end else if (q == 4'd0) begin
          m_wraps++; push = 1'b1;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        if (occ == 2 && !pop) m_ovf = 1;
        else m_fifo.push_back(m_wraps);
      end
    end
    m_prev = int'(q);
  endtask

  task automatic chk_model();
    chk("state8", s8, m_state);  chk("state2", s2, m_state);
    chk("err8", er8, m_err);     chk("err2", er2, m_err);
    chk("ovf8", o8, m_ovf);      chk("ovf2", o2, m_ovf);
    chk("vld8", v8, m_fifo.size() > 0);
    chk("vld2", v2, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("dat8", d8, m_fifo[0] % 256);
      chk("dat2", d2, m_fifo[0] % 4);
    end
    chk("ext8", e8, ((m_wraps % 256) << 4) | m_prev);
    chk("ext2", e2, ((m_wraps % 4) << 4) | m_prev);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state8"}, s8, 0); chk({tag, "_vld8"}, v8, 0); chk({tag, "_dat8"}, d8, 0);
    chk({tag, "_ext8"}, e8, 0);   chk({tag, "_err8"}, er8, 0); chk({tag, "_ovf8"}, o8, 0);
    chk({tag, "_state2"}, s2, 0); chk({tag, "_vld2"}, v2, 0); chk({tag, "_dat2"}, d2, 0);
    chk({tag, "_ext2"}, e2, 0);   chk({tag, "_err2"}, er2, 0); chk({tag, "_ovf2"}, o2, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; snap_ready = 1'b0; c = 0; q = 4'd0;
    m_reset();
    #1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk); #1;
    chk_model();
  endtask

  task automatic adv();
    c = (c + 1) % 16;
    q = 4'(c);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      snap_ready = rdy;
      tick();
      if (cap && v8 && snap_ready) cap8.push_back(int'(d8));
      if (cap && v2 && snap_ready) cap2.push_back(int'(d2));
      adv();
    end
  endtask

  initial begin
    int roll2[5];
    int bias;
    roll2 = '{1, 2, 3, 0, 1};
    cap = 1'b0;
    //             q     clr   rdy  st err vld dat ext
    tbl[0]  = '{4'd0,  1'b0, 1'b1, 1, 0, 0, 0, 0};
    tbl[1]  = '{4'd1,  1'b0, 1'b1, 1, 0, 0, 0, 1};
    tbl[2]  = '{4'd2,  1'b0, 1'b1, 1, 0, 0, 0, 2};
    tbl[3]  = '{4'd2,  1'b0, 1'b1, 2, 1, 0, 0, 2};
    tbl[4]  = '{4'd3,  1'b0, 1'b1, 2, 1, 0, 0, 3};
    tbl[5]  = '{4'd4,  1'b1, 1'b1, 0, 0, 0, 0, 4};
    tbl[6]  = '{4'd14, 1'b0, 1'b1, 1, 0, 0, 0, 14};
    tbl[7]  = '{4'd15, 1'b0, 1'b1, 1, 0, 0, 0, 15};
    tbl[8]  = '{4'd0,  1'b0, 1'b1, 1, 0, 1, 1, 16};
    tbl[9]  = '{4'd1,  1'b0, 1'b0, 1, 0, 1, 1, 17};
    tbl[10] = '{4'd2,  1'b0, 1'b1, 1, 0, 0, 0, 18};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      q = tbl[i].q; clr = tbl[i].clr; snap_ready = tbl[i].rdy;
      @(posedge clk); #1;
      clr = 1'b0;
      chk($sformatf("tbl%0d_state8", i), s8, tbl[i].st);
      chk($sformatf("tbl%0d_state2", i), s2, tbl[i].st);
      chk($sformatf("tbl%0d_err8", i), er8, tbl[i].err);
      chk($sformatf("tbl%0d_vld8", i), v8, tbl[i].vld);
      chk($sformatf("tbl%0d_vld2", i), v2, tbl[i].vld);
      chk($sformatf("tbl%0d_ovf8", i), o8, 0);
      chk($sformatf("tbl%0d_ext8", i), e8, tbl[i].ext);
      chk($sformatf("tbl%0d_ext2", i), e2, tbl[i].ext);
      if (tbl[i].vld != 0) chk($sformatf("tbl%0d_dat8", i), d8, tbl[i].dat);
    end

    // Healthy run and wrap-counter rollover on the narrow instance
    do_reset();
    cap = 1'b1;
    run(17, 1'b1);
    chk("ext_after_first_wrap", e8, 16);
    run(23, 1'b1);
    chk("ext_after_40", e8, 39);
    chk("err_after_40", er8, 0);
    run(50, 1'b1);
    cap = 1'b0;
    chk("snap_count8", cap8.size(), 5);
    chk("snap_count2", cap2.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < cap8.size()) chk($sformatf("snap8_%0d", k), cap8[k], k + 1);
      if (k < cap2.size()) chk($sformatf("snap2_%0d", k), cap2[k], roll2[k]);
    end

    // Backpressure across three wraps
    do_reset();
    run(50, 1'b0);
    chk("bp_ovf8", o8, 1); chk("bp_ovf2", o2, 1);
    chk("bp_vld", v8, 1);  chk("bp_head", d8, 1);
    chk("bp_wrap_cnt", e8[11:4], 3);
    snap_ready = 1'b1;
    tick(); adv();
    chk("bp_second", d8, 2); chk("bp_second_vld", v8, 1);
    tick(); adv();
    chk("bp_drained", v8, 0);

    // Illegal 5 -> 7 step, frozen wrap count, clr recovery
    do_reset();
    run(5, 1'b1);
    snap_ready = 1'b1;
    tick();
    c = 7; q = 4'd7;
    tick();
    chk("ill_err", er8, 1); chk("ill_state", s8, 2); chk("ill_err2", er2, 1);
    adv();
    run(40, 1'b1);
    chk("ill_frozen_wrap", e8[11:4], 0);
    chk("ill_still_fault", s8, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    adv();
    chk("clr_state", s8, 0); chk("clr_err", er8, 0); chk("clr_ovf", o8, 0);
    tick(); adv();
    chk("clr_track", s8, 1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    run(48, 1'b0);
    snap_ready = 1'b1;
    tick(); adv();
    chk("pp_ovf", o8, 0); chk("pp_vld", v8, 1); chk("pp_head", d8, 2);
    tick(); adv();
    chk("pp_next", d8, 3);
    tick(); adv();
    chk("pp_empty", v8, 0);

    // Asynchronous reset between edges while a snapshot is pending
    do_reset();
    run(20, 1'b0);
    chk("arst_pre_vld", v8, 1);
    #1 rst = 1'b1;
    #1 chk_zero("arst");
    do_reset();

    // Randomised traffic: phased backpressure, glitches, clears, occasional resets
    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 24 == 0) bias = $urandom_range(0, 3);
      snap_ready = ($urandom_range(0, 3) < bias);
      clr = ($urandom_range(0, 79) == 0);
      tick();
      clr = 1'b0;
      adv();
      if ($urandom_range(0, 149) == 0) q = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
